// File: rtl/osc_intl_pkg.sv
// Shared definitions for the multi-channel oscillation interlock: FSM states,
// default parameter values and the channel-index width helper.
package osc_intl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EVAL = 2'd2
    } state_e;

    localparam int CH_NUM_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/osc_intl_ch.sv
// One monitored channel: window min/max, peak-to-peak check, leaky counter and
// latched trip flag. Peak-to-peak hold is built only with OSC_INTL_PEAK_HOLD_EN.
module osc_intl_ch
    import osc_intl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_idle,
    input  logic              i_accept,
    input  logic              i_first,
    input  logic              i_eval,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_data_thresh,
    input  logic [CNT_W-1:0]  i_cnt_thresh,
    output logic              o_flag,
    output logic              o_rise
`ifdef OSC_INTL_PEAK_HOLD_EN
    ,output logic [DATA_W:0]  o_peak
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    logic signed [DATA_W-1:0] smp, min_q, min_d, max_q, max_d;
    logic signed [DATA_W:0]   min_x, max_x;
    logic [DATA_W:0]          p2p;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     flag_q, flag_d;
    logic                     over, set_cond;

    assign smp   = $signed(i_data);
    // Sign-extend before subtracting so the full signed range cannot wrap.
    assign min_x = min_q;
    assign max_x = max_q;
    assign p2p   = max_x - min_x;
    assign over  = p2p >= {1'b0, i_data_thresh};

    assign set_cond = i_en && (i_cnt_thresh != '0) && (cnt_q >= i_cnt_thresh);

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (i_idle || !i_en) begin
            min_d = '0;
            max_d = '0;
            cnt_d = '0;
        end else begin
            if (i_accept) begin
                if (i_first) begin
                    min_d = smp;
                    max_d = smp;
                end else begin
                    if (smp < min_q) min_d = smp;
                    if (smp > max_q) max_d = smp;
                end
            end
            if (i_eval) cnt_d = over ? sat_inc(cnt_q) : sat_dec(cnt_q);
        end
        if (i_clr)         flag_d = 1'b0;
        else if (set_cond) flag_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            min_q  <= '0;
            max_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign o_flag = flag_q;
    assign o_rise = set_cond && !flag_q && !i_clr;

`ifdef OSC_INTL_PEAK_HOLD_EN
    logic [DATA_W:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (i_clr)                               peak_d = '0;
        else if (i_eval && i_en && p2p > peak_q) peak_d = p2p;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) peak_q <= '0;
        else        peak_q <= peak_d;
    end

    assign o_peak = peak_q;
`endif

endmodule

// File: rtl/osc_intl_multi.sv
// Multi-channel oscillation interlock top: shared window FSM, sample/window
// counters and first-fault capture. OSC_INTL_PEAK_HOLD_EN adds o_peak_p2p.
module osc_intl_multi
    import osc_intl_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic [CH_NUM-1:0]        i_osc_en,
    input  logic [CH_NUM*DATA_W-1:0] i_data,
    input  logic                     i_data_valid,
    input  logic [DATA_W-1:0]        i_data_thresh,
    input  logic [CNT_W-1:0]         i_cnt_thresh,
    input  logic [31:0]              i_period,
    input  logic [15:0]              i_cycle_cnt,
    output logic [CH_NUM-1:0]        o_osc_flag,
    output logic                     o_first_vld,
    output logic [3:0]               o_first_ch,
    output logic [1:0]               o_state
`ifdef OSC_INTL_PEAK_HOLD_EN
    ,output logic [CH_NUM*(DATA_W+1)-1:0] o_peak_p2p
`endif
);

    localparam int IDX_W = ch_idx_w(CH_NUM);

    state_e            state_q, state_d;
    logic [31:0]       smp_cnt_q, smp_cnt_d;
    logic [15:0]       win_cnt_q, win_cnt_d;
    logic              first_vld_q, first_vld_d;
    logic [3:0]        first_ch_q, first_ch_d;
    logic [CH_NUM-1:0] flag, rise;
    logic [IDX_W-1:0]  low_idx;
    logic [31:0]       period_eff;
    logic              accept, last_smp, win_done, idle, eval, win_first;

    assign period_eff = (i_period == '0) ? 32'd1 : i_period;
    assign idle       = (state_q == IDLE);
    assign eval       = (state_q == EVAL);
    assign accept     = (state_q == RUN) && i_data_valid;
    assign win_first  = (smp_cnt_q == '0);
    // Compare with >= so a period lowered mid-window still closes the window.
    assign last_smp   = accept && (({1'b0, smp_cnt_q} + 33'd1) >= {1'b0, period_eff});
    assign win_done   = (i_cycle_cnt != '0) &&
                        (({1'b0, win_cnt_q} + 17'd1) >= {1'b0, i_cycle_cnt});

    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        win_cnt_d = win_cnt_q;
        case (state_q)
            IDLE: begin
                smp_cnt_d = '0;
                win_cnt_d = '0;
                if (|(i_osc_en & ~flag)) state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    smp_cnt_d = smp_cnt_q + 32'd1;
                    if (last_smp) state_d = EVAL;
                end
            end
            EVAL: begin
                smp_cnt_d = '0;
                win_cnt_d = win_cnt_q + 16'd1;
                state_d   = win_done ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
        if (i_osc_en == '0) state_d = IDLE;
    end

    always_comb begin
        low_idx = '0;
        for (int n = CH_NUM - 1; n >= 0; n--) begin
            if (rise[n]) low_idx = IDX_W'(n);
        end
        first_vld_d = first_vld_q;
        first_ch_d  = first_ch_q;
        if (i_clr) begin
            first_vld_d = 1'b0;
            first_ch_d  = '0;
        end else if (!first_vld_q && (|rise)) begin
            first_vld_d = 1'b1;
            first_ch_d  = 4'(low_idx);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            smp_cnt_q   <= '0;
            win_cnt_q   <= '0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            win_cnt_q   <= win_cnt_d;
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        osc_intl_ch #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_en          (i_osc_en[g]),
            .i_clr         (i_clr),
            .i_idle        (idle),
            .i_accept      (accept),
            .i_first       (win_first),
            .i_eval        (eval),
            .i_data        (i_data[g*DATA_W +: DATA_W]),
            .i_data_thresh (i_data_thresh),
            .i_cnt_thresh  (i_cnt_thresh),
            .o_flag        (flag[g]),
            .o_rise        (rise[g])
`ifdef OSC_INTL_PEAK_HOLD_EN
            ,.o_peak       (o_peak_p2p[g*(DATA_W+1) +: DATA_W+1])
`endif
        );
    end

    assign o_osc_flag  = flag;
    assign o_first_vld = first_vld_q;
    assign o_first_ch  = first_ch_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_osc_intl_multi.sv
// Directed self-checking bench for osc_intl_multi (default build, 4 channels).
module tb_osc_intl_multi;

    localparam int CH_NUM = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     i_clr;
    logic [CH_NUM-1:0]        i_osc_en;
    logic [CH_NUM*DATA_W-1:0] i_data;
    logic                     i_data_valid;
    logic [DATA_W-1:0]        i_data_thresh;
    logic [CNT_W-1:0]         i_cnt_thresh;
    logic [31:0]              i_period;
    logic [15:0]              i_cycle_cnt;
    logic [CH_NUM-1:0]        o_osc_flag;
    logic                     o_first_vld;
    logic [3:0]               o_first_ch;
    logic [1:0]               o_state;

    int n_assert = 0;
    int n_fail   = 0;

    osc_intl_multi #(
        .CH_NUM (CH_NUM),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clr         (i_clr),
        .i_osc_en      (i_osc_en),
        .i_data        (i_data),
        .i_data_valid  (i_data_valid),
        .i_data_thresh (i_data_thresh),
        .i_cnt_thresh  (i_cnt_thresh),
        .i_period      (i_period),
        .i_cycle_cnt   (i_cycle_cnt),
        .o_osc_flag    (o_osc_flag),
        .o_first_vld   (o_first_vld),
        .o_first_ch    (o_first_ch),
        .o_state       (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic send(input logic [127:0] v);
        i_data       = v;
        i_data_valid = 1'b1;
        tick();
        i_data_valid = 1'b0;
    endtask

    // Four samples then the EVAL cycle; returns one cycle after the counter update.
    task automatic win(input logic [127:0] a, b, c, d);
        send(a);
        send(b);
        send(c);
        send(d);
        tick();
    endtask

    // Channels in mask see lo,hi,lo,hi; the others hold base.
    task automatic win_ch(input logic [3:0] mask, input logic [31:0] lo, hi, base);
        logic [127:0] v;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) v[c*32 +: 32] = mask[c] ? ((s % 2 == 0) ? lo : hi) : base;
            send(v);
        end
        tick();
    endtask

    task automatic restart();
        i_clr    = 1'b1;
        i_osc_en = 4'h0;
        tick();
        i_clr    = 1'b0;
        i_osc_en = 4'hF;
        tick();
    endtask

    initial begin
        i_rst         = 1'b0;
        i_clr         = 1'b0;
        i_osc_en      = 4'h0;
        i_data        = '0;
        i_data_valid  = 1'b0;
        i_data_thresh = 32'd100;
        i_cnt_thresh  = 16'd3;
        i_period      = 32'd4;
        i_cycle_cnt   = 16'd0;
        repeat (2) tick();
        chk("reset_flag", 32'(o_osc_flag), 32'h0);
        chk("reset_first_vld", 32'(o_first_vld), 32'h0);
        chk("reset_first_ch", 32'(o_first_ch), 32'h0);
        chk("reset_state", 32'(o_state), 32'h0);

        // ch1 p2p 120 for three windows, trip at T+2 of the third
        i_rst    = 1'b1;
        i_osc_en = 4'hF;
        tick();
        chk("t1_run", 32'(o_state), 32'h1);
        win_ch(4'b0010, -60, 60, 5);
        chk("t1_win1", 32'(o_osc_flag), 32'h0);
        win_ch(4'b0010, -60, 60, 5);
        chk("t1_win2", 32'(o_osc_flag), 32'h0);
        win_ch(4'b0010, -60, 60, 5);
        chk("t1_win3_t1", 32'(o_osc_flag), 32'h0);
        tick();
        chk("t1_trip", 32'(o_osc_flag), 32'h2);
        chk("t1_first_vld", 32'(o_first_vld), 32'h1);
        chk("t1_first_ch", 32'(o_first_ch), 32'h1);

        // alternating p2p 120 / 10: counter 1,0,1,0,1 never reaches 2
        i_cnt_thresh = 16'd2;
        restart();
        chk("t2_cleared", 32'(o_osc_flag), 32'h0);
        chk("t2_first_clr", 32'(o_first_vld), 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) win_ch(4'b0010, -60, 60, 5);
            else            win_ch(4'b0010, 0, 10, 5);
            tick();
            chk("t2_no_trip", 32'(o_osc_flag), 32'h0);
        end

        // ch0 and ch2 trip together, then ch3 later
        i_cnt_thresh = 16'd1;
        restart();
        win_ch(4'b0101, -60, 60, 5);
        chk("t3_latency", 32'(o_osc_flag), 32'h0);
        tick();
        chk("t3_flags", 32'(o_osc_flag), 32'h5);
        chk("t3_first_vld", 32'(o_first_vld), 32'h1);
        chk("t3_first_ch", 32'(o_first_ch), 32'h0);
        win_ch(4'b1101, -60, 60, 5);
        tick();
        chk("t3_ch3_flag", 32'(o_osc_flag), 32'hD);
        chk("t3_first_hold", 32'(o_first_ch), 32'h0);

        // clear against a persisting trip condition
        i_clr = 1'b1;
        tick();
        chk("t4_clr_flag", 32'(o_osc_flag), 32'h0);
        chk("t4_clr_first", 32'(o_first_vld), 32'h0);
        i_clr = 1'b0;
        tick();
        chk("t4_reset_flag", 32'(o_osc_flag), 32'hD);
        chk("t4_refirst_vld", 32'(o_first_vld), 32'h1);
        chk("t4_refirst_ch", 32'(o_first_ch), 32'h0);

        // two-window run then IDLE with counters cleared
        i_cnt_thresh = 16'd3;
        i_cycle_cnt  = 16'd2;
        restart();
        win_ch(4'b0010, -60, 60, 5);
        chk("t5_after_w1", 32'(o_state), 32'h1);
        win_ch(4'b0010, -60, 60, 5);
        chk("t5_after_w2", 32'(o_state), 32'h0);
        i_cycle_cnt = 16'd0;
        tick();
        chk("t5_rerun", 32'(o_state), 32'h1);
        win_ch(4'b0010, -60, 60, 5);
        tick();
        chk("t5_cnt_cleared", 32'(o_osc_flag), 32'h0);

        // drop enable mid-window: IDLE next edge, flag retained
        i_cnt_thresh = 16'd1;
        tick();
        chk("t6_trip", 32'(o_osc_flag), 32'h2);
        send(pk(5, -60, 5, 5));
        send(pk(5, 60, 5, 5));
        i_osc_en = 4'h0;
        tick();
        chk("t6_idle", 32'(o_state), 32'h0);
        chk("t6_retained", 32'(o_osc_flag), 32'h2);

        // asynchronous reset during EVAL
        i_osc_en = 4'hF;
        tick();
        chk("t7_run", 32'(o_state), 32'h1);
        send(pk(1, 2, 3, 4));
        send(pk(1, 2, 3, 4));
        send(pk(1, 2, 3, 4));
        send(pk(1, 2, 3, 4));
        chk("t7_eval", 32'(o_state), 32'h2);
        #2 i_rst = 1'b0;
        #1;
        chk("t7_flag", 32'(o_osc_flag), 32'h0);
        chk("t7_first_vld", 32'(o_first_vld), 32'h0);
        chk("t7_first_ch", 32'(o_first_ch), 32'h0);
        chk("t7_state", 32'(o_state), 32'h0);
        tick();
        i_rst = 1'b1;

        // count threshold 0 disables tripping even with p2p 1000
        i_cnt_thresh = 16'd0;
        tick();
        chk("t8_run", 32'(o_state), 32'h1);
        for (int k = 0; k < 3; k++) begin
            win_ch(4'b0010, -500, 500, 5);
            tick();
            chk("t8_no_trip", 32'(o_osc_flag), 32'h0);
        end
        i_cnt_thresh = 16'd1;
        tick();
        chk("t8_enable_trip", 32'(o_osc_flag), 32'h2);
        chk("t8_first_ch", 32'(o_first_ch), 32'h1);

        // negative samples; p2p 39 below, 40 at, 50 above threshold 40
        i_data_thresh = 32'd40;
        restart();
        win(pk(0, -7, -200, -100), pk(39, -7, -150, -60),
            pk(0, -7, -180, -100), pk(39, -7, -160, -60));
        tick();
        chk("t9_flags", 32'(o_osc_flag), 32'hC);
        chk("t9_first_ch", 32'(o_first_ch), 32'h2);

        // full-range p2p needs DATA_W+1 bits
        i_data_thresh = 32'hFFFF_FFFF;
        restart();
        win(pk(32'h7FFF_FFFF, 32'h8000_0000, 0, 0), pk(32'h8000_0001, 32'h7FFF_FFFF, 0, 0),
            pk(0, 0, 0, 0), pk(0, 0, 0, 0));
        tick();
        chk("t10_flags", 32'(o_osc_flag), 32'h2);
        chk("t10_first_ch", 32'(o_first_ch), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_intl_multi.md
Name: osc_intl_multi

Overview:
Multi-channel successor to the single-channel oscillation interlock. It tracks per-channel min/max of signed fixed-point samples over a programmable sample window. Each window's peak-to-peak value is compared against a threshold and feeds a saturating up/down (leaky) counter per channel. A latched per-channel trip flag and a first-fault channel index go to the MPS interlock aggregator.

Parameters:
CH_NUM, 4, number of monitored channels (1..16)
DATA_W, 32, sample width, signed two's complement
CNT_W, 16, width of leaky counter and count threshold

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_clr  in  1  clears trip flags and first-fault capture
i_osc_en  in  CH_NUM  per-channel enable
i_data  in  CH_NUM*DATA_W  samples, channel n at [n*DATA_W +: DATA_W]
i_data_valid  in  1  one strobe qualifies all channels' samples
i_data_thresh  in  DATA_W  unsigned peak-to-peak threshold
i_cnt_thresh  in  CNT_W  counter trip level; 0 = tripping disabled
i_period  in  32  valid samples per window; 0 treated as 1
i_cycle_cnt  in  16  windows per evaluation run; 0 = run continuously
o_osc_flag  out  CH_NUM  latched trip flags
o_first_vld  out  1  first-fault capture valid
o_first_ch  out  4  index of first tripped channel
o_state  out  2  FSM state

Behaviour:
- Reset: every register and output is 0; FSM enters IDLE.
- FSM encoding: IDLE=0, RUN=1, EVAL=2.
- Any state → IDLE when i_osc_en == 0. This override has priority over all other transitions.
- IDLE → RUN when at least one channel has i_osc_en=1 and o_osc_flag=0. On entry to IDLE, clear the sample counter, window counter, min/max buffers and leaky counters.
- RUN: on each i_data_valid, increment the sample counter.
  - First valid sample of a window: load min and max with the sample. No zero initialisation.
  - Later samples: signed compare; update min if sample < min, update max if sample > max.
- RUN → EVAL on the edge that accepts the i_period-th valid sample. That sample is included in min/max.
- EVAL lasts exactly 1 cycle. Per enabled channel:
  - p2p = max − min, computed in DATA_W+1 bits and always non-negative.
  - Over = (p2p >= zero-extended i_data_thresh).
  - Counter +1 if over, saturating at 2^CNT_W−1. Otherwise −1, floored at 0.
- Leaving EVAL: increment the window counter and clear the sample counter.
  - Go to IDLE if i_cycle_cnt != 0 and the window counter reaches i_cycle_cnt.
  - Otherwise go to RUN.
- i_data_valid during EVAL is ignored; the sample is dropped.
- Disabled channels: buffers and counter held at 0; flag never sets; any existing flag is retained.
- Flag set: o_osc_flag[n] goes high on the edge after counter[n] >= i_cnt_thresh, with i_osc_en[n]=1 and i_cnt_thresh != 0. The flag then stays high.
- Latency: last window sample accepted at edge T → counter updated at T+1 → flag high at T+2.
- Flag clear: i_clr clears all flags, o_first_vld and o_first_ch. Clear wins over a set in the same cycle; a flag whose condition persists re-sets on the following edge.
- First fault: when o_first_vld=0 and at least one flag rises, latch the lowest rising index into o_first_ch and set o_first_vld. Later trips do not update the capture.
- Parameter changes mid-window take effect immediately; no shadowing.

Optional Feature:
OSC_INTL_PEAK_HOLD_EN
- Defined: adds output o_peak_p2p (CH_NUM*(DATA_W+1)), one per channel, holding the largest p2p seen since the last i_clr or reset. It is updated in EVAL and cleared by i_clr.
- Not defined: the port is absent and no peak registers are built.

Decomposition:
- Shared package osc_intl_pkg holds:
  - FSM state constants: IDLE, RUN, EVAL.
  - Default parameter values.
  - Channel index width function (clog2).
- Natural sub-module: osc_intl_ch. One instance per channel via generate, containing min/max tracking, p2p subtraction, leaky counter and flag.
- The top level keeps the shared FSM, sample/window counters and first-fault capture.

Test Plan:
- CH_NUM=4, i_period=4, thresh=100, cnt_thresh=3, i_cycle_cnt=0; ch1 samples −60,+60,−60,+60 (p2p 120), others constant 5 → ch1 flag high at T+2 of 3rd window; o_first_ch=1; other flags 0.
- Same setup, ch1 alternating windows of p2p 120 and p2p 10 → counter oscillates 1,0,1,0; no trip.
- Ch0 and ch2 trip in the same cycle → o_first_ch=0, o_first_vld=1; later ch3 trip leaves o_first_ch=0.
- i_clr asserted in the same cycle as a trip condition → flag stays 0 that edge and is 1 on the next edge.
- i_cycle_cnt=2 → FSM returns to IDLE after 2 EVALs and counters are cleared. Drop i_osc_en to 0 mid-RUN → IDLE next edge with flags retained. Async reset mid-EVAL → all outputs 0.
- i_cnt_thresh=0 with p2p 1000 → no flag ever. Samples all negative (−200..−150) with thresh 40 → p2p 50, over=1, confirming signed handling.
